// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite responder backed by a small register-file memory.
// Address phase is decoded on accept (hsel & hready & htrans[1]); each
// in-range data phase is stretched by WAIT_STATES low-hreadyout cycles.
// Accesses above LIMIT_ADDR get a two-cycle ERROR response.
// Optional build macro: AHB_SLV_SUBWORD_EN (byte/halfword writes with
// alignment checking). Without it every access is a full-word access.
module ahb_slave_mem #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] LIMIT_ADDR  = 32'h0000_003F
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      cnt;
    logic [2:0]      cnt_nxt;
    logic [AW-1:0]   idx_q;
    logic            write_q;
    logic [3:0]      be_q;
    logic [31:0]     mem [DEPTH];

    logic            can_start;
    logic            accept;
    logic            addr_bad;
    logic [3:0]      be_in;

    // A new address phase is only taken when no data phase is stalling.
    assign can_start = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
    assign accept    = hsel & hready & htrans[1] & can_start;

`ifdef AHB_SLV_SUBWORD_EN
    logic align_bad;

    // Lane enables and alignment check from hsize / low address bits.
    always_comb begin
        be_in     = 4'hF;
        align_bad = 1'b0;
        case (hsize)
            3'b000: begin
                be_in = 4'b0001 << haddr[1:0];
            end
            3'b001: begin
                be_in     = haddr[1] ? 4'b1100 : 4'b0011;
                align_bad = haddr[0];
            end
            3'b010: begin
                be_in     = 4'hF;
                align_bad = |haddr[1:0];
            end
            default: begin
                be_in     = 4'h0;
                align_bad = 1'b1;
            end
        endcase
    end

    assign addr_bad = (haddr > LIMIT_ADDR) || align_bad;
`else
    logic unused_bits;

    assign be_in       = 4'hF;
    assign addr_bad    = (haddr > LIMIT_ADDR);
    assign unused_bits = ^{hsize, haddr[1:0]};
`endif

    // State and wait-counter register.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: accept from IDLE/DATA/ERR2, count down in WAIT.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (accept) begin
                    if (addr_bad) begin
                        state_nxt = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = 3'(WAIT_STATES - 1);
                    end else begin
                        state_nxt = S_DATA;
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = S_DATA;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            S_ERR1: begin
                state_nxt = S_ERR2;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Address-phase capture on accept.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            idx_q   <= '0;
            write_q <= 1'b0;
            be_q    <= '0;
        end else if (accept) begin
            idx_q   <= haddr[AW+1:2];
            write_q <= hwrite;
            be_q    <= be_in;
        end
    end

    // Memory: cleared on reset, written at the edge that ends a write DATA phase.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if ((state == S_DATA) && write_q) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

    // Response outputs decoded from the registered state.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;
        case (state)
            S_WAIT: hreadyout = 1'b0;
            S_DATA: begin
                if (!write_q) begin
                    hrdata = mem[idx_q];
                end
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            S_ERR2: hresp = 1'b1;
            default: begin
                hreadyout = 1'b1;
            end
        endcase
    end

endmodule
